bp_update_queue: RTL and testbench

- Sits between ROB retirement and the branch predictor.
- Accepts up to WIDTH branch-resolution updates per cycle (valid, source_pc, target_pc, taken, correct) and stores them in order in a circular FIFO.
- Drains them to the predictor at up to OUT_WIDTH per cycle, so predictor table write ports can be fewer than the retire width.
- Provides ROB backpressure and a sticky overflow flag.

---
 rtl/bp_update_queue.sv | 165 ++++++++++++++++
 tb/tb_bp_update_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_queue.sv
// bp_update_queue
// Branch-resolution update buffer between ROB retirement and the branch
// predictor. Up to WIDTH updates per cycle are compacted into a circular
// FIFO and drained at up to OUT_WIDTH per cycle. in_ready is derived only
// from the registered occupancy; updates that do not fit are dropped and
// latch a sticky overflow flag.

module bp_update_queue #(
  parameter int WIDTH     = 3,
  parameter int OUT_WIDTH = 1,
  parameter int DEPTH     = 8,
  parameter int PC_W      = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,

  input  logic [WIDTH-1:0]          in_valid,
  input  logic [WIDTH*PC_W-1:0]     in_source_pc,
  input  logic [WIDTH*PC_W-1:0]     in_target_pc,
  input  logic [WIDTH-1:0]          in_taken,
  input  logic [WIDTH-1:0]          in_correct,
  output logic                      in_ready,

  input  logic                      out_ready,
  output logic [OUT_WIDTH-1:0]      out_valid,
  output logic [OUT_WIDTH*PC_W-1:0] out_source_pc,
  output logic [OUT_WIDTH*PC_W-1:0] out_target_pc,
  output logic [OUT_WIDTH-1:0]      out_taken,
  output logic [OUT_WIDTH-1:0]      out_correct,

  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] WIDTH_C     = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] OUT_WIDTH_C = CNT_W'(OUT_WIDTH);

  // Entry storage
  logic [PC_W-1:0]  src_q     [DEPTH];
  logic [PC_W-1:0]  src_d     [DEPTH];
  logic [PC_W-1:0]  tgt_q     [DEPTH];
  logic [PC_W-1:0]  tgt_d     [DEPTH];
  logic             taken_q   [DEPTH];
  logic             taken_d   [DEPTH];
  logic             correct_q [DEPTH];
  logic             correct_d [DEPTH];

  // Pointers, occupancy, sticky flag
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  // Per-cycle bookkeeping
  logic [CNT_W-1:0] free_cnt;
  logic [CNT_W-1:0] n_in;
  logic [CNT_W-1:0] n_avail;
  logic [CNT_W-1:0] n_out;
  logic             drop;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;

  // Free space seen by the retire side; same-cycle dequeue is deliberately
  // ignored so in_ready never depends on out_ready.
  assign free_cnt = DEPTH_C - count_q;
  assign in_ready = (free_cnt >= WIDTH_C);

  assign count    = count_q;
  assign overflow = overflow_q;

  // Compact valid lanes in ascending order and write them at tail onward;
  // lanes beyond the free space are dropped.
  always_comb begin
    src_d     = src_q;
    tgt_d     = tgt_q;
    taken_d   = taken_q;
    correct_d = correct_q;
    n_in      = '0;
    drop      = 1'b0;
    wr_idx    = tail_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_valid[i]) begin
        if (n_in < free_cnt) begin
          wr_idx            = tail_q + PTR_W'(n_in);
          src_d[wr_idx]     = in_source_pc[i*PC_W +: PC_W];
          tgt_d[wr_idx]     = in_target_pc[i*PC_W +: PC_W];
          taken_d[wr_idx]   = in_taken[i];
          correct_d[wr_idx] = in_correct[i];
          n_in              = n_in + CNT_W'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  // Present the oldest min(count, OUT_WIDTH) entries; invalid lanes are zero.
  always_comb begin
    out_valid     = '0;
    out_source_pc = '0;
    out_target_pc = '0;
    out_taken     = '0;
    out_correct   = '0;
    rd_idx        = head_q;
    n_avail       = (count_q < OUT_WIDTH_C) ? count_q : OUT_WIDTH_C;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      if (CNT_W'(i) < n_avail) begin
        rd_idx                         = head_q + PTR_W'(i);
        out_valid[i]                   = 1'b1;
        out_source_pc[i*PC_W +: PC_W]  = src_q[rd_idx];
        out_target_pc[i*PC_W +: PC_W]  = tgt_q[rd_idx];
        out_taken[i]                   = taken_q[rd_idx];
        out_correct[i]                 = correct_q[rd_idx];
      end
    end
    n_out = out_ready ? n_avail : '0;
  end

  // Advance pointers and occupancy; overflow only ever sets.
  always_comb begin
    head_d     = head_q + PTR_W'(n_out);
    tail_d     = tail_q + PTR_W'(n_in);
    count_d    = count_q + n_in - n_out;
    overflow_d = overflow_q | drop;
  end

  // Control registers; reset empties the queue immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry array registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        src_q[i]     <= '0;
        tgt_q[i]     <= '0;
        taken_q[i]   <= 1'b0;
        correct_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        src_q[i]     <= src_d[i];
        tgt_q[i]     <= tgt_d[i];
        taken_q[i]   <= taken_d[i];
        correct_q[i] <= correct_d[i];
      end
    end
  end

endmodule

// File: tb/tb_bp_update_queue.sv
// Testbench for bp_update_queue: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.

module tb_bp_update_queue;

  localparam int W   = 3;
  localparam int OW  = 1;
  localparam int D   = 8;
  localparam int PCW = 32;

  typedef struct packed {
    logic [PCW-1:0] src;
    logic [PCW-1:0] tgt;
    logic           taken;
    logic           correct;
  } upd_t;

  logic                  clock;
  logic                  reset_n;
  logic [W-1:0]          in_valid;
  logic [W*PCW-1:0]      in_source_pc;
  logic [W*PCW-1:0]      in_target_pc;
  logic [W-1:0]          in_taken;
  logic [W-1:0]          in_correct;
  logic                  in_ready;
  logic                  out_ready;
  logic [OW-1:0]         out_valid;
  logic [OW*PCW-1:0]     out_source_pc;
  logic [OW*PCW-1:0]     out_target_pc;
  logic [OW-1:0]         out_taken;
  logic [OW-1:0]         out_correct;
  logic [$clog2(D):0]    count;
  logic                  overflow;

  bp_update_queue #(.WIDTH(W), .OUT_WIDTH(OW), .DEPTH(D), .PC_W(PCW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_source_pc  (in_source_pc),
    .in_target_pc  (in_target_pc),
    .in_taken      (in_taken),
    .in_correct    (in_correct),
    .in_ready      (in_ready),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_source_pc (out_source_pc),
    .out_target_pc (out_target_pc),
    .out_taken     (out_taken),
    .out_correct   (out_correct),
    .count         (count),
    .overflow      (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   vectors     = 0;
  int   miscompares = 0;
  int   emitted     = 0;
  upd_t mq[$];
  logic m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int   n;
    upd_t e;
    n = (mq.size() < OW) ? mq.size() : OW;
    chk("count", 64'(count), 64'(mq.size()));
    chk("count_le_depth", 64'(count <= D), 64'd1);
    chk("in_ready", 64'(in_ready), 64'((D - mq.size()) >= W));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("out_valid_thermo", 64'(out_valid), 64'((1 << n) - 1));
    for (int i = 0; i < OW; i++) begin
      e = (i < n) ? mq[i] : '0;
      chk("out_source_pc", 64'(out_source_pc[i*PCW +: PCW]), 64'(e.src));
      chk("out_target_pc", 64'(out_target_pc[i*PCW +: PCW]), 64'(e.tgt));
      chk("out_taken",     64'(out_taken[i]),                64'(e.taken));
      chk("out_correct",   64'(out_correct[i]),              64'(e.correct));
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic step();
    int   free;
    int   npop;
    int   acc;
    upd_t u;
    upd_t tmp[$];
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    free = D - mq.size();
    acc  = 0;
    for (int i = 0; i < W; i++) begin
      if (in_valid[i]) begin
        if (acc < free) begin
          u.src     = in_source_pc[i*PCW +: PCW];
          u.tgt     = in_target_pc[i*PCW +: PCW];
          u.taken   = in_taken[i];
          u.correct = in_correct[i];
          tmp.push_back(u);
          acc++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    npop = out_ready ? ((mq.size() < OW) ? mq.size() : OW) : 0;
    for (int k = 0; k < npop; k++) void'(mq.pop_front());
    emitted += npop;
    foreach (tmp[k]) mq.push_back(tmp[k]);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] v, input int base, input logic rdy);
    in_valid = v;
    for (int i = 0; i < W; i++) begin
      in_source_pc[i*PCW +: PCW] = PCW'(base + 4*i);
      in_target_pc[i*PCW +: PCW] = PCW'(base + 'h1000 + 4*i);
    end
    in_taken   = W'(base >> 2);
    in_correct = ~W'(base >> 2);
    out_ready  = rdy;
  endtask

  initial begin
    int e0;
    int k;
    int nl;
    int guard;

    reset_n = 1'b0;
    drive('0, 0, 1'b0);
    #12 reset_n = 1'b1;

    // Reset then idle
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_out_pc", 64'(out_source_pc), 64'd0);
    step();
    step();

    // Single-cycle burst
    drive(3'b111, 'h100, 1'b1);
    step();
    chk("burst_t1_pc", 64'(out_source_pc[PCW-1:0]), 64'h100);
    chk("burst_t1_cnt", 64'(count), 64'd3);
    drive('0, 0, 1'b1);
    step();
    chk("burst_t2_pc", 64'(out_source_pc[PCW-1:0]), 64'h104);
    chk("burst_t2_cnt", 64'(count), 64'd2);
    step();
    chk("burst_t3_pc", 64'(out_source_pc[PCW-1:0]), 64'h108);
    chk("burst_t3_cnt", 64'(count), 64'd1);
    step();
    chk("burst_empty_cnt", 64'(count), 64'd0);
    chk("burst_empty_vld", 64'(out_valid), 64'd0);

    // Sparse lanes
    drive(3'b101, 'h200, 1'b1);
    step();
    chk("sparse_pc0", 64'(out_source_pc[PCW-1:0]), 64'h200);
    chk("sparse_cnt", 64'(count), 64'd2);
    drive('0, 0, 1'b1);
    step();
    chk("sparse_pc1", 64'(out_source_pc[PCW-1:0]), 64'h208);
    step();

    // Wrap-around stream of 20 sequential PCs
    e0 = emitted;
    k = 0;
    guard = 0;
    while ((emitted - e0) < 20 && guard < 200) begin
      if (k < 20 && in_ready) begin
        nl = (20 - k < W) ? (20 - k) : W;
        drive(W'((1 << nl) - 1), 'h300 + 4*k, 1'b1);
        k += nl;
      end else begin
        drive('0, 0, 1'b1);
      end
      step();
      guard++;
    end
    chk("wrap_timeout", 64'(guard < 200), 64'd1);
    chk("wrap_emitted", 64'(emitted - e0), 64'd20);
    chk("wrap_overflow", 64'(overflow), 64'd0);
    drive('0, 0, 1'b1);
    step();

    // Backpressure and full
    drive(3'b111, 'h400, 1'b0);
    step();
    drive(3'b111, 'h40C, 1'b0);
    step();
    chk("bp_cnt6", 64'(count), 64'd6);
    chk("bp_not_ready", 64'(in_ready), 64'd0);
    chk("bp_hold_pc_a", 64'(out_source_pc[PCW-1:0]), 64'h400);
    drive(3'b111, 'h418, 1'b0);
    step();
    chk("full_cnt8", 64'(count), 64'd8);
    chk("full_overflow", 64'(overflow), 64'd1);
    chk("full_hold_pc", 64'(out_source_pc[PCW-1:0]), 64'h400);
    chk("full_hold_vld", 64'(out_valid), 64'd1);
    drive('0, 0, 1'b0);
    step();
    drive('0, 0, 1'b1);
    repeat (9) step();

    // Async reset mid-operation
    drive(3'b111, 'h500, 1'b0);
    step();
    drive(3'b011, 'h50C, 1'b0);
    step();
    chk("pre_rst_cnt5", 64'(count), 64'd5);
    drive('0, 0, 1'b0);
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_overflow", 64'(overflow), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_pc", 64'(out_source_pc), 64'd0);
    mq.delete();
    m_ovf = 1'b0;
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    drive(3'b001, 'h900, 1'b1);
    step();
    chk("post_rst_first", 64'(out_source_pc[PCW-1:0]), 64'h900);
    chk("post_rst_vld", 64'(out_valid), 64'd1);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      in_valid = W'($urandom_range(0, (1 << W) - 1));
      for (int i = 0; i < W; i++) begin
        in_source_pc[i*PCW +: PCW] = $urandom;
        in_target_pc[i*PCW +: PCW] = $urandom;
      end
      in_taken   = W'($urandom);
      in_correct = W'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    drive('0, 0, 1'b1);
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
